// File: rtl/hilo_muldiv_if.sv
// HI/LO unit bus between the EX stage and the multiply/divide unit.
// A HI/LO op is accepted when op_valid is high in IDLE with flush low. EX then holds it while stallreq is high.
interface hilo_muldiv_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stallreq;
    logic        busy;
    logic [65:0] hilo_bus;
    logic [1:0]  dbg_state;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stallreq, busy, hilo_bus, dbg_state
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stallreq, busy, hilo_bus, dbg_state
    );
endinterface

// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit producing HI/LO writes for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Multiply waits MUL_LAT cycles; divide is restoring radix-2, one quotient bit per cycle.
module hilo_muldiv #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         resetn,
    hilo_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    // One bit wider than the 64-bit partial remainder so the shifted upper half never drops its MSB.
    logic [64:0] rem_q, rem_d;
    logic [31:0] hi_res_q, hi_res_d;
    logic [31:0] lo_res_q, lo_res_d;

    logic        is_muldiv;
    logic [31:0] in_a_mag;
    logic [63:0] ext_a, ext_b, product;
    logic [31:0] b_mag;
    logic [64:0] shifted, rem_step;
    logic [33:0] diff;
    logic [31:0] div_q, div_r;
    logic [65:0] hilo_bus_w;

    assign is_muldiv = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign in_a_mag  = (bus.op == OP_DIV && bus.src_a[31]) ? -bus.src_a : bus.src_a;

    assign ext_a   = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b   = {{32{sgn_q & b_q[31]}}, b_q};
    assign product = ext_a * ext_b;

    assign b_mag    = (sgn_q && b_q[31]) ? -b_q : b_q;
    assign shifted  = {rem_q[63:0], 1'b0};
    assign diff     = {1'b0, shifted[64:32]} - {2'b00, b_mag};
    assign rem_step = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
    assign div_q    = rem_step[31:0];
    assign div_r    = rem_step[63:32];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        rem_d      = rem_q;
        hi_res_d   = hi_res_q;
        lo_res_d   = lo_res_q;
        hilo_bus_w = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = 5'(MUL_LAT - 1);
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                            sgn_d   = (bus.op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = 5'd31;
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                            sgn_d   = (bus.op == OP_DIV);
                            rem_d   = {33'd0, in_a_mag};
                        end
                        OP_MTHI: hilo_bus_w = {2'b10, bus.src_a, 32'd0};
                        OP_MTLO: hilo_bus_w = {2'b01, 32'd0, bus.src_a};
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d  = S_DONE;
                    hi_res_d = product[63:32];
                    lo_res_d = product[31:0];
                end
            end
            S_DIV: begin
                rem_d = rem_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                    // Divide by zero skips sign correction and reports the raw dividend.
                    if (b_q == 32'd0) begin
                        hi_res_d = a_q;
                        lo_res_d = 32'hFFFF_FFFF;
                    end else begin
                        lo_res_d = (sgn_q && (a_q[31] ^ b_q[31])) ? -div_q : div_q;
                        hi_res_d = (sgn_q && a_q[31]) ? -div_r : div_r;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    hilo_bus_w = {2'b11, hi_res_q, lo_res_q};
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            rem_q    <= '0;
            hi_res_q <= '0;
            lo_res_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            rem_q    <= rem_d;
            hi_res_q <= hi_res_d;
            lo_res_q <= lo_res_d;
        end
    end

    assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.stallreq  = ((state_q == S_IDLE) && bus.op_valid && is_muldiv) || bus.busy;
    assign bus.hilo_bus  = hilo_bus_w;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed test-plan cases plus random MULT/DIV traffic
// checked against an arithmetic reference model.
module tb_hilo_muldiv;
    localparam int unsigned MUL_LAT = 1;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    hilo_muldiv_if bus();

    hilo_muldiv #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                sq = sa * sb;
                return sq;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit flush_done);
        logic [63:0] exp;
        int          lat;
        int          cycles;
        bit          bad_we;
        exp    = ref_hilo(op, a, b);
        lat    = (op < 3'd2) ? int'(MUL_LAT) + 1 : 33;
        cycles = 0;
        bad_we = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        while (bus.stallreq === 1'b1 && cycles < 200) begin
            cycles++;
            if (bus.hilo_bus[65:64] !== 2'b00) bad_we = 1'b1;
            @(negedge clk);
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            #1;
        end
        check($sformatf("latency op%0d", op), 66'(cycles), 66'(lat));
        check("stall_we", 66'(bad_we), 66'd0);
        if (flush_done) begin
            bus.flush = 1'b1;
            #1;
            check("flush_done_we", 66'(bus.hilo_bus[65:64]), 66'd0);
        end else begin
            check($sformatf("result op%0d %h %h", op, a, b), bus.hilo_bus, {2'b11, exp});
        end
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        check("idle_bus", bus.hilo_bus, 66'd0);
        check("idle_state", 66'(bus.dbg_state), 66'd0);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        logic [65:0] exp;
        exp = (op == 3'd4) ? {2'b10, a, 32'd0} : {2'b01, 32'd0, a};
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        #1;
        check($sformatf("mt_bus op%0d", op), bus.hilo_bus, exp);
        check("mt_stall", 66'(bus.stallreq), 66'd0);
        bus.flush = 1'b1;
        #1;
        check("mt_flush", bus.hilo_bus, 66'd0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        check("mt_state", 66'(bus.dbg_state), 66'd0);
    endtask

    task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int k, input bit use_reset);
        bit bad_we;
        bad_we = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        repeat (k) begin
            @(negedge clk);
            #1;
            if (bus.hilo_bus[65:64] !== 2'b00) bad_we = 1'b1;
        end
        if (use_reset) resetn = 1'b0;
        else bus.flush = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        resetn    = 1'b1;
        #1;
        check("flush_busy", 66'(bus.busy), 66'd0);
        check("flush_stall", 66'(bus.stallreq), 66'd0);
        check("flush_state", 66'(bus.dbg_state), 66'd0);
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.hilo_bus[65:64] !== 2'b00) bad_we = 1'b1;
        end
        check(use_reset ? "reset_no_we" : "flush_no_we", 66'(bad_we), 66'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        n_tests      = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reset_bus", bus.hilo_bus, 66'd0);
        check("reset_stall", 66'(bus.stallreq), 66'd0);
        check("reset_busy", 66'(bus.busy), 66'd0);
        check("reset_state", 66'(bus.dbg_state), 66'd0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd3, 32'd100, 32'd7, 1'b0);
        run_op(3'd3, 32'h64, 32'd0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FF9C, 32'd0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run_mt(3'd4, 32'h1234_5678);
        run_mt(3'd5, 32'h9ABC_DEF0);
        run_flush(3'd2, 32'd1000, 32'd3, 10, 1'b0);
        run_flush(3'd2, 32'd1000, 32'd3, 10, 1'b1);
        run_flush(3'd0, 32'd7, 32'd9, 1, 1'b0);
        run_op(3'd3, 32'd77, 32'd5, 1'b1);
        run_op(3'd1, 32'd3, 32'd5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'hFFFF_FFFF;
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else b = $urandom;
            run_op(op, a, b, ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
